// File: rtl/exhaustive_stim_capture.sv
// exhaustive_stim_capture: sweeps every input vector into a DUT, captures {stim, resp} into a FWFT FIFO
// and folds each captured entry into a CRC-style running signature.
module exhaustive_stim_capture #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4,
  parameter int GRAY   = 0
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  output logic [N_IN-1:0]         stim,
  input  logic [N_OUT-1:0]        resp,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [N_IN+N_OUT-1:0]   rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             signature
);
  localparam int EW = N_IN + N_OUT;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, APPLY, CAPTURE, STALL, DONE} state_t;
  state_t state, state_next;

  logic [N_IN:0]   index;
  logic [15:0]     settle_cnt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, last, settled, launch, wr, pop;
  logic [EW-1:0]   entry;
  logic [15:0]     entry16;

  assign launch  = start && (state == IDLE || state == DONE);
  assign full    = count == CW'(DEPTH);
  assign last    = index == (N_IN+1)'(2**N_IN - 1);
  assign settled = settle_cnt == 16'(SETTLE - 1);
  assign wr      = (state == CAPTURE || state == STALL) && !full;
  assign pop     = rd_valid && rd_ready;
  assign entry   = {stim, resp};

  // Only the low 16 bits of the zero-extended entry feed the signature.
  if (EW >= 16) begin : g_trunc
    assign entry16 = entry[15:0];
  end else begin : g_ext
    assign entry16 = {{(16-EW){1'b0}}, entry};
  end

  always_ff @(posedge CK)
    state <= !reset ? IDLE : state_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE:     state_next = start ? APPLY : state;
      APPLY:          state_next = settled ? CAPTURE : APPLY;
      CAPTURE, STALL: state_next = full ? STALL : last ? DONE : APPLY;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = state == APPLY || state == CAPTURE || state == STALL;
    done = state == DONE;
    stim = !busy ? '0 : (GRAY != 0) ? index[N_IN-1:0] ^ index[N_IN:1] : index[N_IN-1:0];
  end

  always_ff @(posedge CK) begin
    if (!reset || launch) begin
      index      <= '0;
      settle_cnt <= '0;
      signature  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      settle_cnt <= (state == APPLY && !settled) ? settle_cnt + 16'd1 : '0;
      if (wr) begin
        index     <= index + 1'b1;
        signature <= {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ entry16;
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge CK)
    if (wr) mem[wr_ptr] <= entry;

  assign rd_valid = count != '0;
  assign rd_data  = mem[rd_ptr];
endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb_exhaustive_stim_capture: scoreboard bench over a default, a 3-input/shallow-FIFO and a Gray-order instance.
module tb_exhaustive_stim_capture;
  logic CK = 0;
  logic reset = 0;
  always #5 CK = ~CK;

  logic start_a = 0, rd_ready_a = 1, mode_a = 0;
  logic [1:0] stim_a;
  logic [0:0] resp_a;
  logic rd_valid_a, busy_a, done_a;
  logic [2:0] rd_data_a;
  logic [15:0] sig_a;
  assign resp_a = mode_a ? (stim_a[1] & stim_a[0]) : 1'b0;

  logic start_b = 0, rd_ready_b = 0;
  logic [2:0] stim_b;
  logic [0:0] resp_b;
  logic rd_valid_b, busy_b, done_b;
  logic [3:0] rd_data_b;
  logic [15:0] sig_b;
  assign resp_b = 1'b0;

  logic start_c = 0, rd_ready_c = 1;
  logic [1:0] stim_c;
  logic [0:0] resp_c;
  logic rd_valid_c, busy_c, done_c;
  logic [2:0] rd_data_c;
  logic [15:0] sig_c;
  assign resp_c = 1'b0;

  exhaustive_stim_capture dut_a (
    .CK(CK), .reset(reset), .start(start_a), .stim(stim_a), .resp(resp_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a), .signature(sig_a));

  exhaustive_stim_capture #(.N_IN(3), .DEPTH(4)) dut_b (
    .CK(CK), .reset(reset), .start(start_b), .stim(stim_b), .resp(resp_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .signature(sig_b));

  exhaustive_stim_capture #(.GRAY(1)) dut_c (
    .CK(CK), .reset(reset), .start(start_c), .stim(stim_c), .resp(resp_c),
    .rd_valid(rd_valid_c), .rd_ready(rd_ready_c), .rd_data(rd_data_c),
    .busy(busy_c), .done(done_c), .signature(sig_c));

  int checks = 0;
  int failures = 0;
  logic [2:0] q_a[$];
  logic [3:0] q_b[$];

  logic [2:0] tab_and[4]  = '{3'b000, 3'b010, 3'b100, 3'b111};
  logic [2:0] tab_zero[4] = '{3'b000, 3'b010, 3'b100, 3'b110};
  logic [3:0] tab_b[8]    = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE};
  logic [1:0] tab_gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: compare the FIFO head whenever a pop is about to happen.
  always @(negedge CK)
    if (reset && rd_valid_a && rd_ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_entry actual=%0h required=none", rd_data_a);
      end else chk("a_entry", 32'(rd_data_a), 32'(q_a.pop_front()));
    end

  always @(negedge CK)
    if (reset && rd_valid_b && rd_ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_entry actual=%0h required=none", rd_data_b);
      end else chk("b_entry", 32'(rd_data_b), 32'(q_b.pop_front()));
    end

  task automatic sweep_a(input bit m, input bit extra, input logic [15:0] exp_sig, input string tag);
    int cyc;
    mode_a = m;
    for (int k = 0; k < 4; k++) q_a.push_back(m ? tab_and[k] : tab_zero[k]);
    @(posedge CK); #1 start_a = 1;
    @(posedge CK); #1 start_a = 0;
    cyc = 1;
    while (!done_a && cyc < 40) begin
      start_a = extra && cyc == 3;
      @(posedge CK); #1 cyc++;
    end
    start_a = 0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'd9);
    chk({tag, "_signature"}, 32'(sig_a), 32'(exp_sig));
    chk({tag, "_busy_low"}, 32'(busy_a), 32'd0);
    @(posedge CK); #1;
    chk({tag, "_drained"}, 32'(q_a.size()), 32'd0);
    chk({tag, "_rd_valid_low"}, 32'(rd_valid_a), 32'd0);
    chk({tag, "_done_held"}, 32'(done_a), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_stim", 32'(stim_a), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_signature", 32'(sig_a), 32'd0);
    reset = 1;

    sweep_a(1'b1, 1'b0, 16'h0007, "and_sweep");
    sweep_a(1'b0, 1'b0, 16'h0006, "zero_sweep");
    sweep_a(1'b1, 1'b1, 16'h0007, "start_while_busy");

    // Reset in the middle of the second vector
    mode_a = 1;
    q_a.push_back(3'b000);
    @(posedge CK); #1 start_a = 1;
    @(posedge CK); #1 start_a = 0;
    @(posedge CK); #1;
    @(posedge CK); #1;
    chk("mid_second_vec_stim", 32'(stim_a), 32'd1);
    @(negedge CK); #1 reset = 0;
    @(posedge CK); #1;
    chk("mid_rst_stim", 32'(stim_a), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_signature", 32'(sig_a), 32'd0);
    chk("mid_rst_first_entry_seen", 32'(q_a.size()), 32'd0);
    reset = 1;
    sweep_a(1'b1, 1'b0, 16'h0007, "after_reset");

    // Back-pressure: FIFO fills after four writes and the sweep stalls on vector 4
    @(posedge CK); #1 start_b = 1;
    @(posedge CK); #1 start_b = 0;
    repeat (14) @(posedge CK);
    #1;
    chk("stall_stim", 32'(stim_b), 32'd4);
    chk("stall_busy", 32'(busy_b), 32'd1);
    chk("stall_done", 32'(done_b), 32'd0);
    chk("stall_head", 32'(rd_data_b), 32'd0);
    for (int k = 0; k < 8; k++) q_b.push_back(tab_b[k]);
    rd_ready_b = 1;
    cyc = 0;
    while (!done_b && cyc < 60) begin
      @(posedge CK); #1 cyc++;
    end
    chk("b_done", 32'(done_b), 32'd1);
    repeat (6) @(posedge CK);
    #1;
    chk("b_drained", 32'(q_b.size()), 32'd0);
    chk("b_rd_valid_low", 32'(rd_valid_b), 32'd0);
    chk("b_signature", 32'(sig_b), 32'h001E);

    // Gray order: each code held for SETTLE+1 = 2 cycles
    @(posedge CK); #1 start_c = 1;
    @(posedge CK); #1 start_c = 0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("gray_stim_c%0d", c), 32'(stim_c), 32'(tab_gray[(c-1)/2]));
      @(posedge CK); #1;
    end
    chk("gray_done", 32'(done_c), 32'd1);
    chk("gray_done_stim", 32'(stim_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exhaustive_stim_capture.md
EXHAUSTIVE_STIM_CAPTURE -- requirements
Module: exhaustive_stim_capture

Interface
REQ-001 SHALL have parameter N_IN, default 2, DUT input width (1..16).
REQ-002 SHALL have parameter N_OUT, default 1, DUT response width (1..16).
REQ-003 SHALL have parameter SETTLE, default 1, cycles between stim update and response sample (>=1).
REQ-004 SHALL have parameter DEPTH, default 4, capture FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter GRAY, default 0, 0 = binary sweep order, 1 = Gray-code sweep order.
REQ-006 SHALL use one clock and a synchronous, active-low reset, with ports named as below.
REQ-007 CK  input  1  clock, all state updates on rising edge.
REQ-008 reset  input  1  synchronous active-low reset.
REQ-009 start  input  1  sweep request pulse.
REQ-010 stim  output  N_IN  vector driven to DUT.
REQ-011 resp  input  N_OUT  DUT response.
REQ-012 rd_valid  output  1  FIFO non-empty.
REQ-013 rd_ready  input  1  consumer accepts rd_data.
REQ-014 rd_data  output  N_IN+N_OUT  head entry {stim, resp}, stim in MSBs.
REQ-015 busy  output  1  sweep in progress.
REQ-016 done  output  1  sweep complete.
REQ-017 signature  output  16  running response signature.

Function
REQ-018 SHALL implement states IDLE, APPLY, CAPTURE, STALL, DONE.
REQ-019 IDLE/DONE: start=1 -> APPLY next cycle; index=0, signature=0, done=0, FIFO flushed.
REQ-020 start in APPLY/CAPTURE/STALL SHALL be ignored.
REQ-021 stim SHALL equal index (GRAY=0) or index^(index>>1) (GRAY=1) while busy; 0 in IDLE/DONE.
REQ-022 APPLY SHALL last exactly SETTLE cycles, then CAPTURE.
REQ-023 CAPTURE with FIFO not full SHALL write {stim, resp} and update signature in that cycle.
REQ-024 CAPTURE with FIFO full (evaluated at cycle start; same-cycle pop not counted) SHALL go to STALL, holding stim and index.
REQ-025 STALL SHALL retry the write each cycle, performing REQ-023 on the first cycle FIFO is not full.
REQ-026 After a write: index = 2^N_IN-1 -> DONE, else index+1 -> APPLY.
REQ-027 index SHALL be N_IN+1 bits wide; no wrap-around before DONE.
REQ-028 Unstalled vector period SHALL be SETTLE+1 cycles; done SHALL rise 2^N_IN*(SETTLE+1)+1 cycles after start is sampled.
REQ-029 signature_next = (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ low 16 bits of zero-extended {stim, resp}.
REQ-030 busy=1 in APPLY/CAPTURE/STALL only; done=1 in DONE only, held until start or reset.
REQ-031 FIFO SHALL be first-word-fall-through; pop when rd_valid && rd_ready; pop on empty ignored.
REQ-032 Simultaneous write and pop (FIFO not full) SHALL both take effect, occupancy unchanged.
REQ-033 FIFO contents SHALL stay readable in DONE; signature held.

Reset
REQ-034 reset=0 at a rising edge SHALL, from any state including mid-sweep, force IDLE, index=0, stim=0, FIFO empty (rd_valid=0), busy=0, done=0, signature=0.
REQ-035 rd_data value while rd_valid=0 is don't-care.

Verification
REQ-036 Defaults, rd_ready=1, resp=stim[1]&stim[0], start at cycle 0 -> rd_data sequence 000,010,100,111; done=1 at cycle 9; signature=16'h0007.
REQ-037 Defaults, resp=0 -> entries 000,010,100,110; signature=16'h0006.
REQ-038 N_IN=3, DEPTH=4, rd_ready=0 -> four writes, then STALL with stim=3'b100, busy=1; raise rd_ready -> eight entries 0..7 in order, then done=1.
REQ-039 GRAY=1, N_IN=2 -> stim sequence 00,01,11,10, each held SETTLE+1 cycles.
REQ-040 reset=0 during second vector -> next cycle stim=0, rd_valid=0, busy=0, done=0, signature=0; new start gives full sweep from index 0.
REQ-041 start pulsed while busy -> no restart; sweep order and done timing unchanged versus REQ-036.
